// File: rtl/instr_register_fifo_if.sv
// instr_register_fifo_if: load/read handshake and status bundle for the instruction register FIFO.
interface instr_register_fifo_if #(
   parameter int OP_W  = 32,
   parameter int DEPTH = 32
);
   localparam int AW = $clog2(DEPTH);
   logic              load_en;
   logic [3:0]        opcode;
   logic [OP_W-1:0]   operand_a;
   logic [OP_W-1:0]   operand_b;
   logic              load_ready;
   logic              rd_en;
   logic              instr_valid;
   logic [3:0]        instr_opcode;
   logic [OP_W-1:0]   instr_op_a;
   logic [OP_W-1:0]   instr_op_b;
   logic [2*OP_W-1:0] instr_result;
   logic              instr_illegal;
   logic [AW-1:0]     write_pointer;
   logic [AW-1:0]     read_pointer;
   logic [AW:0]       count;
   logic              full;
   logic              empty;
   logic              overflow;
   modport master (
      output load_en, opcode, operand_a, operand_b, rd_en,
      input  load_ready, instr_valid, instr_opcode, instr_op_a, instr_op_b, instr_result,
             instr_illegal, write_pointer, read_pointer, count, full, empty, overflow
   );
   modport slave (
      input  load_en, opcode, operand_a, operand_b, rd_en,
      output load_ready, instr_valid, instr_opcode, instr_op_a, instr_op_b, instr_result,
             instr_illegal, write_pointer, read_pointer, count, full, empty, overflow
   );
endinterface

// File: rtl/instr_register_fifo.sv
// instr_register_fifo: show-ahead FIFO of {opcode, a, b, result} words, result computed at write time.
module instr_register_fifo #(
   parameter int OP_W  = 32,
   parameter int DEPTH = 32
) (
   input logic                 clk,
   input logic                 reset,
   instr_register_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int RW = 2 * OP_W;
   logic [3:0]      op_mem [DEPTH];
   logic [OP_W-1:0] a_mem  [DEPTH];
   logic [OP_W-1:0] b_mem  [DEPTH];
   logic [RW-1:0]   r_mem  [DEPTH];
   logic [DEPTH-1:0] ill_mem;
   logic [AW-1:0]   wp, rp;
   logic [AW:0]     cnt;
   logic            ovf, full, empty, wr, rd, illegal, b_zero;
   logic signed [RW-1:0] a_x, b_x, quo, rem;
   logic [RW-1:0]   res;
   always_comb begin
      full    = cnt == (AW+1)'(DEPTH);
      empty   = cnt == '0;
      rd      = bus.rd_en && !empty;
      wr      = bus.load_en && (!full || rd);
      illegal = bus.opcode[3];
      a_x     = {{OP_W{bus.operand_a[OP_W-1]}}, bus.operand_a};
      b_x     = {{OP_W{bus.operand_b[OP_W-1]}}, bus.operand_b};
      b_zero  = b_x == '0;
      // divide/remainder kept in their own signed statements so the mux below cannot strip signedness
      quo     = a_x / b_x;
      rem     = a_x % b_x;
      res     = illegal                   ? '0 :
                bus.opcode[2:0] == 3'd1   ? a_x :
                bus.opcode[2:0] == 3'd2   ? b_x :
                bus.opcode[2:0] == 3'd3   ? a_x + b_x :
                bus.opcode[2:0] == 3'd4   ? a_x - b_x :
                bus.opcode[2:0] == 3'd5   ? a_x * b_x :
                bus.opcode[2:0] == 3'd6   ? (b_zero ? '0 : quo) :
                bus.opcode[2:0] == 3'd7   ? (b_zero ? '0 : rem) : '0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else begin
         if (wr) wp <= wp + AW'(1);
         if (rd) rp <= rp + AW'(1);
         cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
         if (bus.load_en && !wr) ovf <= 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (wr && !reset) begin
         op_mem[wp]  <= bus.opcode;
         a_mem[wp]   <= bus.operand_a;
         b_mem[wp]   <= bus.operand_b;
         r_mem[wp]   <= res;
         ill_mem[wp] <= illegal;
      end
   end
   assign bus.load_ready    = !full || rd;
   assign bus.instr_valid   = !empty;
   assign bus.instr_opcode  = empty ? '0 : op_mem[rp];
   assign bus.instr_op_a    = empty ? '0 : a_mem[rp];
   assign bus.instr_op_b    = empty ? '0 : b_mem[rp];
   assign bus.instr_result  = empty ? '0 : r_mem[rp];
   assign bus.instr_illegal = !empty && ill_mem[rp];
   assign bus.write_pointer = wp;
   assign bus.read_pointer  = rp;
   assign bus.count         = cnt;
   assign bus.full          = full;
   assign bus.empty         = empty;
   assign bus.overflow      = ovf;
endmodule

// File: doc/instr_register_fifo.md
Name: instr_register_fifo

Overview:
- Parametrised next-generation instruction register.
- Stores {opcode, operand_a, operand_b, result} words in a circular buffer of DEPTH entries. The result is computed at write time.
- Read side is a show-ahead FIFO with an explicit pop, plus full/empty/count status and a sticky overflow flag.
- Sits between the stimulus/driver side (load) and the checker/consumer side (read). Replaces the fixed 32-entry, externally-addressed register file.

Parameters:
- OP_W, 32, operand width in bits (signed two's complement), legal range 4..32.
- DEPTH, 32, number of entries, power of two, 2..256.
- AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- load_en  input  1  write request for the current operands/opcode.
- opcode  input  4  operation code: 0 ZERO, 1 PASSA, 2 PASSB, 3 ADD, 4 SUB, 5 MULT, 6 DIV, 7 MOD; 8..15 illegal.
- operand_a  input  OP_W  signed operand A.
- operand_b  input  OP_W  signed operand B.
- load_ready  output  1  high when a write this cycle will be accepted.
- rd_en  input  1  pop request for the head entry.
- instr_valid  output  1  head entry present (== !empty).
- instr_opcode  output  4  head opcode.
- instr_op_a  output  OP_W  head operand A.
- instr_op_b  output  OP_W  head operand B.
- instr_result  output  2*OP_W  head result (signed).
- instr_illegal  output  1  head entry was written with an illegal opcode.
- write_pointer  output  AW  next write slot.
- read_pointer  output  AW  head slot.
- count  output  AW+1  occupied entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky: a load was dropped.

Behaviour:
- Interface decision: one clock, clk. Reset is synchronous and active-high, sampled only on the rising edge of clk.
- Reset state: write_pointer=0, read_pointer=0, count=0, empty=1, full=0, overflow=0, load_ready=1.
- Storage array is not cleared by reset. All instr_* outputs read 0 while empty.
- Reset overrides load_en and rd_en in the same cycle. Asserting reset mid-stream discards all contents.
- Accept write (wr) = load_en && (!full || (rd_en && !empty)). load_ready is the same expression with load_en removed.
- Accept read (rd) = rd_en && !empty. rd_en while empty is ignored: no pointer change, no error.
- On wr: the entry at write_pointer captures opcode, operand_a, operand_b, the computed result and the illegal bit. write_pointer increments, wrapping DEPTH-1 -> 0.
- On rd: read_pointer increments, wrapping DEPTH-1 -> 0.
- count: +1 on wr only, -1 on rd only, unchanged when both occur or neither occurs.
- When full, a simultaneous rd and wr are both accepted and count stays at DEPTH.
- load_en && !wr (full, no pop) drops the load: no state change except overflow<=1.
- overflow clears only on reset.
- Latency:
  - An entry written at edge N is visible on instr_* and instr_valid=1 after edge N, provided the FIFO was empty.
  - Outputs are show-ahead: the head is always presented combinationally from storage at read_pointer.
  - After a pop at edge N, the next entry is presented after edge N.
- Arithmetic: operands are sign-extended to 2*OP_W before computing; the result is a 2*OP_W signed value.
  - ZERO -> 0.
  - PASSA -> a.
  - PASSB -> b.
  - ADD -> a+b.
  - SUB -> a-b.
  - MULT -> full signed product.
  - DIV -> quotient truncated toward zero.
  - MOD -> remainder with the sign of a.
- DIV or MOD with b=0 -> result 0, no other effect.
- Most-negative a DIV -1 -> +2^(OP_W-1), which is representable in the result width.
- Illegal opcode (8..15): the entry is stored, with result=0 and illegal bit=1.

Test Plan:
- OP_W=8, DEPTH=4 unless noted.
- Reset, then idle 3 cycles -> empty=1, full=0, count=0, pointers 0, instr_result=0, load_ready=1, overflow=0.
- Load (ADD,5,-3), (SUB,5,-3), (MULT,-128,-128), (DIV,-7,2) on consecutive cycles, then pop 4 -> results in order are 2, 8, 16384, -3; count goes 1,2,3,4 then back to 0; full=1 after the 4th load.
- Fill 4 entries, then load_en with rd_en=0 -> load dropped, overflow=1, count=4. Next cycle load_en=1 and rd_en=1 -> both accepted, count=4, write_pointer wraps 0->1, read_pointer 0->1.
- (DIV,9,0), (MOD,-7,2), (DIV,-128,-1), opcode 12 with (3,4) -> results 0, -1, 128, and 0 with instr_illegal=1.
- Load 3 entries, assert reset for 1 cycle together with load_en=1 and rd_en=1 -> afterwards count=0, empty=1, overflow=0, nothing written.
- 10 alternating single load/pop pairs with DEPTH=4 -> pointers wrap twice, each popped entry matches the load order, count never exceeds 1, overflow stays 0.
